// File: rtl/pps_mem_access_pkg.sv
// rtl/pps_mem_access_pkg.sv - shared type codes, FSM states and defaults for the MEM-stage load/store unit
package pps_mem_access_pkg;

  // Access-type codes carried on MEM_memop_type_in
  localparam int tMEM_OP_NULL   = 0;
  localparam int tMEM_OP_BYTE   = 1;
  localparam int tMEM_OP_BYTEU  = 2;
  localparam int tMEM_OP_HWORD  = 3;
  localparam int tMEM_OP_HWORDU = 4;
  localparam int tMEM_OP_WORD   = 5;
  localparam int tMEM_OP_DWORD  = 6;

  // Default number of ACCESS cycles without ack before the access is abandoned
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/pps_mem_align.sv
// rtl/pps_mem_align.sv - combinational misalignment check, byte enables, store lane shift, load extract/extend
module pps_mem_align
  import pps_mem_access_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int MEM_OP_TYPE_SIZE = 7,
  localparam int BE_W            = DATA_W / 8,
  localparam int OFF_W           = $clog2(BE_W)
) (
  input  logic [MEM_OP_TYPE_SIZE-1:0] memop_type,
  input  logic [OFF_W-1:0]            off,
  input  logic                        memwr,
  input  logic [DATA_W-1:0]           st_data,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        misaligned,
  output logic [BE_W-1:0]             bwe,
  output logic [DATA_W-1:0]           st_lane,
  output logic [DATA_W-1:0]           ld_ext
);

  logic [3:0]        size_bytes;
  logic              sext;
  logic [6:0]        bit_sh;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;

  // Decode the type code into an access size in bytes and a sign-extension flag
  always_comb begin
    size_bytes = 4'd0;
    sext       = 1'b0;
    case (int'(memop_type))
      tMEM_OP_BYTE:   begin size_bytes = 4'd1; sext = 1'b1; end
      tMEM_OP_BYTEU:  begin size_bytes = 4'd1; sext = 1'b0; end
      tMEM_OP_HWORD:  begin size_bytes = 4'd2; sext = 1'b1; end
      tMEM_OP_HWORDU: begin size_bytes = 4'd2; sext = 1'b0; end
      tMEM_OP_WORD:   begin size_bytes = 4'd4; sext = 1'b1; end
      tMEM_OP_DWORD:  begin size_bytes = 4'd8; sext = 1'b1; end
      default:        ;
    endcase
  end

  // Unknown codes and accesses wider than the bus count as misaligned, else require natural alignment
  always_comb begin
    if (size_bytes == 4'd0 || int'(size_bytes) > BE_W)
      misaligned = 1'b1;
    else
      misaligned = (32'(off) & (32'(size_bytes) - 32'd1)) != 32'd0;
  end

  assign bwe     = memwr ? (BE_W'((32'd1 << size_bytes) - 32'd1) << off) : '0;
  assign st_lane = st_data << {off, 3'b000};

  // Load path: move the addressed lane to bit 0, keep its bytes, and fill above with sign or zero
  assign bit_sh   = {size_bytes, 3'b000};
  assign lane     = ld_data >> {off, 3'b000};
  assign keep     = (int'(size_bytes) >= BE_W) ? '1 : ~({DATA_W{1'b1}} << bit_sh);
  assign sign_bit = |(lane & (keep ^ (keep >> 1)));
  assign ld_ext   = (lane & keep) | ((sext && sign_bit) ? ~keep : '0);

endmodule

// File: rtl/pps_mem_access.sv
// rtl/pps_mem_access.sv - MEM-stage load/store unit with SRAM req/ack handshake, stall, exceptions and timeout
module pps_mem_access
  import pps_mem_access_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int MEM_OP_TYPE_SIZE = 7,
  parameter int TIMEOUT          = TIMEOUT_DEF,
  localparam int BE_W            = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MEM_valid_in,
  input  logic                        MEM_memop_in,
  input  logic                        MEM_memwr_in,
  input  logic [MEM_OP_TYPE_SIZE-1:0] MEM_memop_type_in,
  input  logic [ADDR_W-1:0]           MEM_Addr_in,
  input  logic [DATA_W-1:0]           MEM_STData_in,
  input  logic [DATA_W-1:0]           MEM_ALUOut_in,
  input  logic [4:0]                  MEM_inst_rd_in,
  input  logic                        MEM_RegWrite_in,
  input  logic                        MEM_ack_in,
  input  logic [DATA_W-1:0]           MEM_LDData_in,
  output logic                        MEM_req_out,
  output logic                        MEM_wr_out,
  output logic [ADDR_W-1:0]           MEM_Addr_out,
  output logic [BE_W-1:0]             MEM_bwe_out,
  output logic [DATA_W-1:0]           MEM_STData_out,
  output logic                        MEM_stall_out,
  output logic                        MEM_valid_out,
  output logic [DATA_W-1:0]           MEM_MUXOut_out,
  output logic [4:0]                  MEM_inst_rd_out,
  output logic                        MEM_RegWrite_out,
  output logic                        MEM_adel_out,
  output logic                        MEM_ades_out,
  output logic                        MEM_timeout_out
);

  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                      state;
  logic [CNT_W-1:0]            wait_cnt;
  logic [MEM_OP_TYPE_SIZE-1:0] acc_type;
  logic [OFF_W-1:0]            acc_off;
  logic [4:0]                  acc_rd;
  logic                        acc_regwrite;

  logic [MEM_OP_TYPE_SIZE-1:0] align_type;
  logic [OFF_W-1:0]            align_off;
  logic                        misaligned;
  logic [BE_W-1:0]             bwe_c;
  logic [DATA_W-1:0]           st_lane;
  logic [DATA_W-1:0]           ld_ext;

  // In IDLE the aligner looks at the incoming instruction; in ACCESS at the latched one for load extraction
  assign align_type    = (state == ST_ACCESS) ? acc_type : MEM_memop_type_in;
  assign align_off     = (state == ST_ACCESS) ? acc_off  : MEM_Addr_in[OFF_W-1:0];
  assign MEM_stall_out = (state == ST_ACCESS);

  pps_mem_align #(
    .DATA_W           (DATA_W),
    .MEM_OP_TYPE_SIZE (MEM_OP_TYPE_SIZE)
  ) u_align (
    .memop_type (align_type),
    .off        (align_off),
    .memwr      (MEM_memwr_in),
    .st_data    (MEM_STData_in),
    .ld_data    (MEM_LDData_in),
    .misaligned (misaligned),
    .bwe        (bwe_c),
    .st_lane    (st_lane),
    .ld_ext     (ld_ext)
  );

  // Request/acknowledge FSM with registered SRAM outputs and writeback results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      acc_type         <= '0;
      acc_off          <= '0;
      acc_rd           <= '0;
      acc_regwrite     <= 1'b0;
      MEM_req_out      <= 1'b0;
      MEM_wr_out       <= 1'b0;
      MEM_Addr_out     <= '0;
      MEM_bwe_out      <= '0;
      MEM_STData_out   <= '0;
      MEM_valid_out    <= 1'b0;
      MEM_MUXOut_out   <= '0;
      MEM_inst_rd_out  <= '0;
      MEM_RegWrite_out <= 1'b0;
      MEM_adel_out     <= 1'b0;
      MEM_ades_out     <= 1'b0;
      MEM_timeout_out  <= 1'b0;
    end else begin
      MEM_valid_out   <= 1'b0;
      MEM_adel_out    <= 1'b0;
      MEM_ades_out    <= 1'b0;
      MEM_timeout_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MEM_valid_in) begin
            if (!MEM_memop_in) begin
              MEM_valid_out    <= 1'b1;
              MEM_MUXOut_out   <= MEM_ALUOut_in;
              MEM_inst_rd_out  <= MEM_inst_rd_in;
              MEM_RegWrite_out <= MEM_RegWrite_in;
            end else if (misaligned) begin
              MEM_valid_out    <= 1'b1;
              MEM_adel_out     <= !MEM_memwr_in;
              MEM_ades_out     <= MEM_memwr_in;
              MEM_MUXOut_out   <= '0;
              MEM_inst_rd_out  <= MEM_inst_rd_in;
              MEM_RegWrite_out <= 1'b0;
            end else begin
              state          <= ST_ACCESS;
              wait_cnt       <= '0;
              MEM_req_out    <= 1'b1;
              MEM_wr_out     <= MEM_memwr_in;
              MEM_Addr_out   <= {MEM_Addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              MEM_bwe_out    <= bwe_c;
              MEM_STData_out <= st_lane;
              acc_type       <= MEM_memop_type_in;
              acc_off        <= MEM_Addr_in[OFF_W-1:0];
              acc_rd         <= MEM_inst_rd_in;
              acc_regwrite   <= MEM_RegWrite_in;
            end
          end
        end
        ST_ACCESS: begin
          if (MEM_ack_in) begin
            state            <= ST_IDLE;
            wait_cnt         <= '0;
            MEM_req_out      <= 1'b0;
            MEM_wr_out       <= 1'b0;
            MEM_bwe_out      <= '0;
            MEM_valid_out    <= 1'b1;
            MEM_inst_rd_out  <= acc_rd;
            MEM_MUXOut_out   <= MEM_wr_out ? '0 : ld_ext;
            MEM_RegWrite_out <= MEM_wr_out ? 1'b0 : acc_regwrite;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state            <= ST_IDLE;
            wait_cnt         <= '0;
            MEM_req_out      <= 1'b0;
            MEM_wr_out       <= 1'b0;
            MEM_bwe_out      <= '0;
            MEM_valid_out    <= 1'b1;
            MEM_timeout_out  <= 1'b1;
            MEM_inst_rd_out  <= acc_rd;
            MEM_RegWrite_out <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pps_mem_access.md
Name: pps_mem_access

Overview:
- Next-generation MEM-stage load/store unit for the MIPS1000 pipeline, sitting between EX/MEM pipeline register and the data SRAM port.
- Generalises data alignment to DATA_W = 32 or 64 and adds a registered request/acknowledge SRAM handshake with wait states, pipeline stall, misaligned-address exceptions, and an access timeout.
- Non-memory instructions pass through with one-cycle registered latency.

Parameters:
- DATA_W, 32, datapath and SRAM data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- BE_W, DATA_W/8, byte-enable width (derived, not overridden).
- MEM_OP_TYPE_SIZE, 7, width of the access-type code.
- TIMEOUT, 255, maximum ACCESS cycles without ack before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- MEM_valid_in  in  1  instruction present.
- MEM_memop_in  in  1  memory access.
- MEM_memwr_in  in  1  store when set, load when clear.
- MEM_memop_type_in  in  MEM_OP_TYPE_SIZE  access type code.
- MEM_Addr_in  in  ADDR_W  effective address.
- MEM_STData_in  in  DATA_W  store data, right-justified.
- MEM_ALUOut_in  in  DATA_W  ALU result.
- MEM_inst_rd_in  in  5  destination register.
- MEM_RegWrite_in  in  1  register write enable.
- MEM_ack_in  in  1  SRAM completes the current access.
- MEM_LDData_in  in  DATA_W  SRAM read data, valid with ack.
- MEM_req_out  out  1  SRAM request.
- MEM_wr_out  out  1  SRAM write.
- MEM_Addr_out  out  ADDR_W  SRAM address, low log2(BE_W) bits forced to 0.
- MEM_bwe_out  out  BE_W  byte write enables.
- MEM_STData_out  out  DATA_W  lane-aligned store data.
- MEM_stall_out  out  1  hold upstream stage.
- MEM_valid_out  out  1  result valid.
- MEM_MUXOut_out  out  DATA_W  writeback data.
- MEM_inst_rd_out  out  5  destination register.
- MEM_RegWrite_out  out  1  gated register write.
- MEM_adel_out  out  1  load address error.
- MEM_ades_out  out  1  store address error.
- MEM_timeout_out  out  1  access aborted.

Behaviour:
- Reset: every output is 0, state is IDLE, timeout counter is 0. Reset mid-ACCESS drops MEM_req_out asynchronously, and any later ack is ignored.
- FSM has two states, IDLE and ACCESS. MEM_stall_out = (state == ACCESS).
- IDLE, valid & !memop: register ALUOut, rd, RegWrite; MEM_valid_out = 1 next cycle.
- IDLE, valid & memop, misaligned:
  - Misaligned means HWORD/HWORDU with addr[0]; WORD with addr[1:0] != 0; DWORD with addr[2:0] != 0.
  - DWORD when DATA_W = 32 is always misaligned; an unknown type code is treated the same way.
  - No request is issued. Next cycle: valid_out = 1, adel_out (load) or ades_out (store) = 1, RegWrite_out = 0.
- IDLE, valid & memop, aligned: latch address, type, aligned store data, bwe, rd, RegWrite; go to ACCESS.
- ACCESS:
  - req_out = 1; Addr/bwe/STData/wr_out are registered and held stable until ack.
  - bwe = 0 for loads. Stores use lane masks: BYTE = 1 << off; HWORD = 2'b11 << off; WORD = 4'hF << off; DWORD = all ones. off = addr[log2(BE_W)-1:0].
  - Store data = STData_in << (8*off).
- ack sampled at a rising edge in ACCESS:
  - Loads: extract the addressed lane. BYTE/HWORD/WORD are sign-extended to DATA_W; BYTEU/HWORDU are zero-extended.
  - Stores produce MEM_MUXOut_out = 0 and RegWrite_out = 0.
  - Go to IDLE; valid_out = 1 next cycle.
- Zero-wait latency: accept at edge N, req visible cycle N+1, ack at edge N+2, result valid cycle N+2 → N+3.
- Timeout: the counter increments each ACCESS cycle without ack. When it reaches TIMEOUT: drop req, return to IDLE, and next cycle valid_out = 1, timeout_out = 1, RegWrite_out = 0.
- ack and the timeout limit in the same cycle: ack wins.
- Inputs presented during ACCESS are ignored; upstream holds them under stall, and they are accepted in the first IDLE cycle.
- valid_out, adel_out, ades_out and timeout_out are one-cycle pulses.
- MEM_ack_in outside ACCESS is ignored.

Decomposition:
- Shared defines file (MIPS1000_defines.v) holds:
  - type codes tMEM_OP_NULL = 0, BYTE = 1, BYTEU = 2, HWORD = 3, HWORDU = 4, WORD = 5, DWORD = 6;
  - state encodings;
  - TIMEOUT default.
- One combinational sub-module, pps_mem_align (parameter DATA_W), provides misalignment detect, bwe generation, store lane shift, and load extract/extend; the FSM stays in the top module.

Test Plan:
- DATA_W=32, SB addr 0x103, data 0xAB, ack after 2 waits → bwe 4'b1000, STData_out 0xAB000000, Addr_out 0x100, stall high 3 cycles, RegWrite_out 0.
- LB addr 0x101, LDData 0x0000_8000 → MUXOut 0xFFFFFF80; LBU → 0x00000080; LHU addr 0x102, LDData 0xBEEF0000 → 0x0000BEEF.
- LW addr 0x102 → no req, adel_out pulse, RegWrite_out 0; SH addr 0x101 → ades_out pulse.
- DATA_W=64, LW addr 0x104, LDData 0x8000_0001_0000_0000 → MUXOut 0xFFFF_FFFF_8000_0001; SD addr 0x8 → bwe 8'hFF.
- TIMEOUT=4, no ack → req drops after 4 cycles, timeout_out pulse; ack coinciding with limit → normal completion, no timeout.
- rst asserted mid-ACCESS → req_out 0 immediately, late ack ignored, next ADD passes through with ALUOut 0x1234 one cycle later.
